// File: rtl/key_counter_gen.sv
// Free-running test-pattern counter with debounced run/pause and direction keys,
// programmable prescale, synchronous load and a one-cycle wrap pulse.
module key_counter_gen #(
  parameter int WIDTH      = 48,
  parameter int PRESCALE_W = 8,
  parameter int DB_CYCLES  = 740000,
  parameter int DB_W       = 20
) (
  input  logic                  clk_video,
  input  logic                  KEY0,
  input  logic                  key_run,
  input  logic                  key_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  dir_down,
  output logic                  wrap
);

  typedef enum logic {ST_RUN, ST_PAUSE} state_e;

  localparam logic [DB_W-1:0]       DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]       DB_ONE   = DB_W'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);
  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);

  // Index 0 is key_run, index 1 is key_mode.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            db_q, db_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            press_q, press_d;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tick;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  wrap_q, wrap_d;

  // A level change is accepted only after DB_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
    press_d = db_q & ~db_d;
  end

  always_comb begin
    state_d = state_q;
    if (press_q[0]) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
    dir_d = dir_q ^ press_q[1];
  end

  // The >= compare lets a lowered prescale take effect on the very next cycle.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (state_q == ST_RUN) begin
      if (pre_q >= prescale) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end
    if (load || (state_q == ST_RUN && state_d == ST_PAUSE)) begin
      pre_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (tick) begin
      if (dir_q) begin
        count_d = count_q - CNT_ONE;
        wrap_d  = (count_q == '0);
      end else begin
        count_d = count_q + CNT_ONE;
        wrap_d  = &count_q;
      end
    end
  end

  always_ff @(posedge clk_video or negedge KEY0) begin
    if (!KEY0) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      db_q     <= 2'b11;
      db_cnt_q <= '0;
      press_q  <= 2'b00;
      state_q  <= ST_RUN;
      dir_q    <= 1'b0;
      pre_q    <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      sync1_q  <= {key_mode, key_run};
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      pre_q    <= pre_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count    = count_q;
  assign running  = (state_q == ST_RUN);
  assign dir_down = dir_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_key_counter_gen.sv
// Scoreboard bench for key_counter_gen: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_key_counter_gen;

  logic       clk;
  logic       KEY0;
  logic       key_run;
  logic       key_mode;
  logic [7:0] prescale;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       running;
  logic       dir_down;
  logic       wrap;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] mask;
    logic [7:0] cnt;
    logic       run;
    logic       dir;
    logic       wr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   check_cnt = 0;
  int   pass_cnt = 0;
  int   t;

  key_counter_gen #(
    .WIDTH(8), .PRESCALE_W(8), .DB_CYCLES(4), .DB_W(3)
  ) dut (
    .clk_video (clk),
    .KEY0      (KEY0),
    .key_run   (key_run),
    .key_mode  (key_mode),
    .prescale  (prescale),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .running   (running),
    .dir_down  (dir_down),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rk, input logic mk, input logic ld, input logic [7:0] lv);
    key_run    = rk;
    key_mode   = mk;
    load       = ld;
    load_value = lv;
  endtask

  task automatic push(input int at, input string nm, input logic [3:0] m,
                      input logic [7:0] c, input logic r, input logic d, input logic w);
    exp_t e;
    e.cyc  = at;
    e.name = nm;
    e.mask = m;
    e.cnt  = c;
    e.run  = r;
    e.dir  = d;
    e.wr   = w;
    sb.push_back(e);
  endtask

  task automatic exp_c(input int at, input string nm, input logic [7:0] c, input logic w);
    push(at, nm, 4'b1001, c, 1'b0, 1'b0, w);
  endtask

  task automatic exp_f(input int at, input string nm, input logic r, input logic d);
    push(at, nm, 4'b0110, 8'h00, r, d, 1'b0);
  endtask

  task automatic exp_all(input int at, input string nm, input logic [7:0] c,
                         input logic r, input logic d, input logic w);
    push(at, nm, 4'b1111, c, r, d, w);
  endtask

  task automatic cmpField(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s %s at cycle %0d: got %h, required %h", nm, fld, cyc, act, req);
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.mask[0]) cmpField(e.name, "count",    count,              e.cnt);
    if (e.mask[1]) cmpField(e.name, "running",  {7'b0, running},    {7'b0, e.run});
    if (e.mask[2]) cmpField(e.name, "dir_down", {7'b0, dir_down},   {7'b0, e.dir});
    if (e.mask[3]) cmpField(e.name, "wrap",     {7'b0, wrap},       {7'b0, e.wr});
  endtask

  // Monitor: compare every expectation stamped for the cycle just completed.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check_cnt++;
        $display("[TB] FAIL %s late: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else begin
        checkOutput(e);
      end
    end
  end

  initial begin
    KEY0 = 1'b0;
    prescale = 8'd0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(3);

    // Reset values, then free count at prescale 0
    t = cyc;
    exp_all(t, "reset", 8'h00, 1'b1, 1'b0, 1'b0);
    KEY0 = 1'b1;
    exp_c(t + 1, "step1", 8'h01, 1'b0);
    exp_c(t + 2, "step2", 8'h02, 1'b0);
    exp_all(t + 3, "step3", 8'h03, 1'b1, 1'b0, 1'b0);
    waitCycles(3);

    // Upward wrap
    t = cyc;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE);
    exp_c(t + 1, "ld_fe", 8'hFE, 1'b0);
    exp_c(t + 2, "up_ff", 8'hFF, 1'b0);
    exp_c(t + 3, "up_wrap", 8'h00, 1'b1);
    exp_c(t + 4, "up_post", 8'h01, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(3);

    // Direction key press, then downward wrap
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    exp_f(t + 6, "mode_pre", 1'b1, 1'b0);
    exp_f(t + 7, "mode_tog", 1'b1, 1'b1);
    exp_c(t + 7, "mode_cnt", 8'h08, 1'b0);
    waitCycles(8);
    t = cyc;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01);
    exp_c(t + 1, "ld_01", 8'h01, 1'b0);
    exp_c(t + 2, "dn_00", 8'h00, 1'b0);
    exp_c(t + 3, "dn_wrap", 8'hFF, 1'b1);
    exp_c(t + 4, "dn_post", 8'hFE, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(3);

    // Short glitches on key_run are rejected
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      waitCycles(3);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      waitCycles(3);
      exp_f(cyc, "glitch", 1'b1, 1'b1);
    end
    exp_c(cyc, "glitch_cnt", 8'hE0, 1'b0);

    // Long press pauses exactly 3+DB_CYCLES edges later
    t = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    exp_f(t + 6, "hold_pre", 1'b1, 1'b1);
    exp_f(t + 7, "hold_pause", 1'b0, 1'b1);
    exp_c(t + 7, "hold_cnt", 8'hD9, 1'b0);
    exp_c(t + 9, "freeze", 8'hD9, 1'b0);
    waitCycles(10);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

    // Load while paused
    t = cyc;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
    exp_c(t + 1, "pause_ld", 8'h55, 1'b0);
    exp_c(t + 4, "pause_hold", 8'h55, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(6);

    // Resume with prescale 3, then lower it to 1 mid-period
    t = cyc;
    prescale = 8'd3;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    exp_f(t + 6, "resume_pre", 1'b0, 1'b1);
    exp_f(t + 7, "resume", 1'b1, 1'b1);
    exp_c(t + 10, "ps3_wait", 8'h55, 1'b0);
    exp_c(t + 11, "ps3_first", 8'h54, 1'b0);
    exp_c(t + 14, "ps3_hold", 8'h54, 1'b0);
    exp_c(t + 15, "ps3_second", 8'h53, 1'b0);
    exp_c(t + 19, "ps3_third", 8'h52, 1'b0);
    exp_c(t + 21, "ps3_mid", 8'h52, 1'b0);
    waitCycles(9);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(12);
    prescale = 8'd1;
    exp_c(t + 22, "ps1_now", 8'h51, 1'b0);
    exp_c(t + 23, "ps1_hold", 8'h51, 1'b0);
    exp_c(t + 24, "ps1_step", 8'h50, 1'b0);
    exp_c(t + 26, "ps1_step2", 8'h4F, 1'b0);
    waitCycles(5);

    // Load beats a due tick that would wrap
    t = cyc;
    prescale = 8'd0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01);
    exp_c(t + 1, "prio_ld1", 8'h01, 1'b0);
    exp_c(t + 2, "prio_zero", 8'h00, 1'b0);
    exp_c(t + 3, "ld_prio", 8'h00, 1'b0);
    exp_c(t + 4, "prio_wrap", 8'hFF, 1'b1);
    exp_c(t + 5, "prio_post", 8'hFE, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(2);

    // Both keys at once toggle on the same edge
    t = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    exp_f(t + 6, "both_pre", 1'b1, 1'b1);
    exp_all(t + 7, "both", 8'hF7, 1'b0, 1'b0, 1'b0);
    exp_c(t + 8, "both_frz", 8'hF7, 1'b0);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(6);

    // Reset mid-debounce with the key still held afterwards
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    waitCycles(3);
    KEY0 = 1'b0;
    exp_all(t + 3, "rst_mid", 8'h00, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    KEY0 = 1'b1;
    exp_f(t + 11, "rst_pre", 1'b1, 1'b0);
    exp_all(t + 12, "rst_tog", 8'h07, 1'b1, 1'b1, 1'b0);
    exp_c(t + 13, "rst_down", 8'h06, 1'b0);
    waitCycles(8);

    // Reset mid-debounce with the key released: no toggle
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    waitCycles(2);
    KEY0 = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    exp_all(t + 15, "rst2", 8'h00, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    KEY0 = 1'b1;
    exp_all(t + 29, "rst2_quiet", 8'h0D, 1'b1, 1'b0, 1'b0);
    waitCycles(14);

    for (int i = 0; i < 20 && sb.size() > 0; i++) waitCycles(1);
    while (sb.size() > 0) begin
      check_cnt++;
      $display("[TB] FAIL %s never checked: pending at cycle %0d, required cycle %0d", sb[0].name, cyc, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
